counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
- Sequencer for the LED counter datapath: turns two raw active-low push buttons into clean, single-cycle control events.
- Runs an internal CNT_W-bit counter in one of three modes: manual step, auto-run and hold/clear.
- Sits between the pmod button pins and the LED outputs; replaces button-as-clock counting with a fully synchronous design on the board clock.

Parameters:
- CNT_W, 4, counter width in bits (drives LED count).
- DB_CYCLES, 120000, consecutive stable samples required to accept a button level change (10 ms at 12 MHz); minimum 2.
- AUTO_DIV, 1200000, clk cycles per auto-run tick (100 ms at 12 MHz); minimum 2.

Ports:
- clk  input  1  board clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_n  input  2  raw asynchronous buttons, active-low; [0]=step, [1]=mode.
- cnt  output  CNT_W  counter value, drives LEDs.
- mode  output  2  current state code (see package).
- dir  output  1  auto-run direction, 1=up, 0=down.
- tick  output  1  one-cycle pulse on every auto-run tick.

Behaviour:
- Reset values (rst sampled high at a clk edge): cnt=0, mode=MANUAL, dir=1, tick=0. Synchronizer flops=1 (released). Debounced levels=released. Debounce and prescaler counters=0. Reset mid-press: the button is treated as released; a held button produces a press only once it has been debounced after rst deasserts.
- Input path per button:
  - 2-flop synchronizer.
  - Debounce counter increments while the synchronized value differs from the debounced level; it clears when they are equal.
  - When the counter reaches DB_CYCLES-1 and the values still differ, the debounced level flips and the counter clears.
  - Press pulse = debounced transition released->pressed, registered, exactly 1 cycle. Releases generate no event.
- Latency: cnt changes exactly DB_CYCLES+3 rising edges after the first edge that samples btn_n[0] low, given a clean press in MANUAL.
- Glitches shorter than DB_CYCLES synchronized cycles produce no event.
- FSM, codes MANUAL=2'd0, AUTO=2'd1, HOLD=2'd2; 2'd3 is illegal and recovers to MANUAL on the next edge.
  - mode press: MANUAL->AUTO->HOLD->MANUAL.
  - step press in MANUAL: cnt <= cnt+1.
  - step press in AUTO: dir <= ~dir; cnt unchanged on that edge.
  - step press in HOLD: cnt <= 0.
- Auto-run: the prescaler counts 0..AUTO_DIV-1 only while in AUTO.
  - At AUTO_DIV-1: tick=1 for one cycle, and cnt <= cnt+1 (dir=1) or cnt-1 (dir=0) on the same edge.
  - The prescaler clears on AUTO entry and on AUTO exit.
- Wrap-around: cnt arithmetic is modulo 2^CNT_W (max->0 up, 0->max down).
- Simultaneous events:
  - mode and step presses on the same cycle: the mode transition wins; step is discarded.
  - Step press coinciding with an auto tick: the direction toggles and the tick still applies using the old dir.
- dir persists across mode changes; only rst sets it to 1.

Optional Feature:
- Macro CNT_SATURATE_EN.
- Defined: cnt saturates at 2^CNT_W-1 when counting up and at 0 when counting down. tick still pulses at saturation. HOLD clear still works.
- Undefined: modulo wrap as above.

Decomposition:
- Package counter_ctrl_pkg: mode_t enum (MANUAL, AUTO, HOLD) with the 2-bit codes above; BTN_STEP=0 and BTN_MODE=1 index constants.
- Sub-module btn_debounce (parameter DB_CYCLES; ports clk, rst, btn_n, level, press): synchronizer, debounce and press pulse. Instantiated twice.
- FSM, prescaler and counter live in the top level.

Test Plan (bench uses DB_CYCLES=4, AUTO_DIV=8, CNT_W=4):
- Reset then one clean step press (low 20 cycles) -> cnt 0->1 exactly 7 edges after first low sample; no change on release.
- 3-cycle low glitch on btn_n[0] -> no press, cnt unchanged; 16 step presses in MANUAL -> cnt wraps 15->0 (saturate build: stays 15).
- mode press -> mode=1; 3 ticks at 8-cycle spacing -> cnt+3. Step press -> dir=0, next 2 ticks -> cnt-2. Wrap 0->15 when down.
- mode press to HOLD -> ticks stop, mode=2; step press -> cnt=0; mode press -> mode=0, dir retained 0.
- Both buttons pressed on the same cycle in MANUAL -> mode=AUTO, cnt unchanged.
- rst asserted mid-AUTO with step held -> next edge cnt=0, mode=0, dir=1, tick=0; held button yields one press after debounce.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared mode encoding and button index constants for the LED counter sequencer.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        HOLD   = 2'd2
    } mode_t;

    localparam int unsigned BTN_STEP = 0;
    localparam int unsigned BTN_MODE = 1;

endpackage

// File: rtl/btn_debounce.sv
// Button input path: 2-flop synchronizer, stable-sample debounce and a one-cycle press pulse.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int unsigned DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync_q1;
    logic            sync_q2;
    logic            level_q;
    logic            press_q;
    logic [DB_W-1:0] db_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1  <= 1'b1;
            sync_q2  <= 1'b1;
            level_q  <= 1'b1;
            press_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync_q1 <= btn_n;
            sync_q2 <= sync_q1;
            press_q <= 1'b0;
            if (sync_q2 == level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                level_q  <= sync_q2;
                db_cnt_q <= '0;
                // Only a released (1) -> pressed (0) flip raises the pulse.
                press_q  <= level_q;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// LED counter sequencer: debounced step/mode buttons drive a manual/auto/hold counter FSM.
// Build option: define CNT_SATURATE_EN to saturate the counter instead of wrapping.
module counter_seq_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned DB_CYCLES = 120000,
    parameter int unsigned AUTO_DIV  = 1200000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       btn_n,
    output logic [CNT_W-1:0] cnt,
    output logic [1:0]       mode,
    output logic             dir,
    output logic             tick
);

    localparam int unsigned PS_W = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(AUTO_DIV - 1);

    logic [1:0]       press;
    logic [1:0]       unused_level;
    logic [CNT_W-1:0] cnt_q;
    mode_t            mode_q;
    logic             dir_q;
    logic             tick_q;
    logic [PS_W-1:0]  presc_q;
    logic             ps_wrap;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_step (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_n[BTN_STEP]),
        .level (unused_level[BTN_STEP]),
        .press (press[BTN_STEP])
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_mode (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_n[BTN_MODE]),
        .level (unused_level[BTN_MODE]),
        .press (press[BTN_MODE])
    );

    function automatic logic [CNT_W-1:0] step_cnt(input logic [CNT_W-1:0] v, input logic up);
`ifdef CNT_SATURATE_EN
        if (up) begin
            return (&v) ? v : v + CNT_W'(1);
        end
        return (v == '0) ? v : v - CNT_W'(1);
`else
        return up ? v + CNT_W'(1) : v - CNT_W'(1);
`endif
    endfunction

    assign ps_wrap = (mode_q == AUTO) && (presc_q == PS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            mode_q  <= MANUAL;
            dir_q   <= 1'b1;
            tick_q  <= 1'b0;
            presc_q <= '0;
        end else begin
            tick_q <= 1'b0;
            case (mode_q)
                MANUAL: begin
                    if (press[BTN_MODE]) begin
                        mode_q  <= AUTO;
                        presc_q <= '0;
                    end else if (press[BTN_STEP]) begin
                        cnt_q <= step_cnt(cnt_q, 1'b1);
                    end
                end
                AUTO: begin
                    // The tick uses dir_q before any toggle on this same edge.
                    if (ps_wrap) begin
                        tick_q  <= 1'b1;
                        cnt_q   <= step_cnt(cnt_q, dir_q);
                        presc_q <= '0;
                    end else begin
                        presc_q <= presc_q + PS_W'(1);
                    end
                    if (press[BTN_MODE]) begin
                        mode_q  <= HOLD;
                        presc_q <= '0;
                    end else if (press[BTN_STEP]) begin
                        dir_q <= ~dir_q;
                    end
                end
                HOLD: begin
                    if (press[BTN_MODE]) begin
                        mode_q <= MANUAL;
                    end else if (press[BTN_STEP]) begin
                        cnt_q <= '0;
                    end
                end
                default: mode_q <= MANUAL;
            endcase
        end
    end

    assign cnt  = cnt_q;
    assign mode = mode_q;
    assign dir  = dir_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl (DB_CYCLES=4, AUTO_DIV=8, CNT_W=4).
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_n;
    logic [3:0] cnt;
    logic [1:0] mode;
    logic       dir;
    logic       tick;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [1:0] mask;
        int         low;
        int         idle;
        logic [3:0] cnt;
        logic [1:0] mode;
        logic       dir;
    } vec_t;
    vec_t tbl[17];

    logic [3:0] ec;
    logic [3:0] prev;

    always #5 clk = ~clk;

    counter_seq_ctrl #(
        .CNT_W     (4),
        .DB_CYCLES (4),
        .AUTO_DIV  (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_n),
        .cnt   (cnt),
        .mode  (mode),
        .dir   (dir),
        .tick  (tick)
    );

    function automatic logic [3:0] exp_up(input logic [3:0] x);
`ifdef CNT_SATURATE_EN
        return (x == 4'd15) ? x : x + 4'd1;
`else
        return x + 4'd1;
`endif
    endfunction

    function automatic logic [3:0] exp_dn(input logic [3:0] x);
`ifdef CNT_SATURATE_EN
        return (x == 4'd0) ? x : x - 4'd1;
`else
        return x - 4'd1;
`endif
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sb_push(input string name, input logic [3:0] c, input logic [1:0] m,
                           input logic d, input logic t);
        exp_t e;
        e.name = name;
        e.val  = {c, m, d, t};
        exp_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t       e;
        logic [7:0] act;
        act = {cnt, mode, dir, tick};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got cnt=%0d mode=%0d dir=%0d tick=%0d, want an entry",
                     act[7:4], act[3:2], act[1], act[0]);
        end else begin
            e = exp_q.pop_front();
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got cnt=%0d mode=%0d dir=%0d tick=%0d, want cnt=%0d mode=%0d dir=%0d tick=%0d",
                         e.name, act[7:4], act[3:2], act[1], act[0],
                         e.val[7:4], e.val[3:2], e.val[1], e.val[0]);
            end
        end
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        btn_n = ~v.mask;
        sb_push(name, v.cnt, v.mode, v.dir, 1'b0);
        wait_cyc(v.low);
        btn_n = 2'b11;
        wait_cyc(v.idle);
        sb_check();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, want $finish before time limit");
        $fatal(1);
    end

    initial begin
        // Glitch first (no event), then 16 clean step presses in MANUAL.
        tbl[0] = '{mask: 2'b01, low: 3, idle: 12, cnt: 4'd1, mode: 2'd0, dir: 1'b1};
        ec = 4'd1;
        for (int i = 1; i < 17; i++) begin
            ec = exp_up(ec);
            tbl[i] = '{mask: 2'b01, low: 8, idle: 10, cnt: ec, mode: 2'd0, dir: 1'b1};
        end

        rst   = 1'b1;
        btn_n = 2'b11;
        wait_cyc(3);
        rst = 1'b0;
        sb_push("reset", 4'd0, 2'd0, 1'b1, 1'b0);
        sb_check();

        // Clean step press: cnt changes exactly 7 edges after first low sample.
        btn_n = 2'b10;
        sb_push("latency_before", 4'd0, 2'd0, 1'b1, 1'b0);
        wait_cyc(6);
        sb_check();
        sb_push("latency_edge7", 4'd1, 2'd0, 1'b1, 1'b0);
        wait_cyc(1);
        sb_check();
        wait_cyc(13);
        btn_n = 2'b11;
        sb_push("release_no_event", 4'd1, 2'd0, 1'b1, 1'b0);
        wait_cyc(12);
        sb_check();

        for (int i = 0; i < 17; i++) begin
            apply_vec(tbl[i], (i == 0) ? "glitch" : $sformatf("step_%0d", i));
        end

        // Both buttons on the same cycle: mode wins, cnt unchanged.
        btn_n = 2'b00;
        sb_push("both_to_auto", ec, 2'd1, 1'b1, 1'b0);
        wait_cyc(7);
        sb_check();
        wait_cyc(1);
        btn_n = 2'b11;
        wait_cyc(7);
        ec = exp_up(ec);
        sb_push("tick_1", ec, 2'd1, 1'b1, 1'b1);
        sb_check();
        wait_cyc(1);
        sb_push("tick_1_end", ec, 2'd1, 1'b1, 1'b0);
        sb_check();
        wait_cyc(7);
        ec = exp_up(ec);
        sb_push("tick_2", ec, 2'd1, 1'b1, 1'b1);
        sb_check();
        wait_cyc(8);
        ec = exp_up(ec);
        sb_push("tick_3", ec, 2'd1, 1'b1, 1'b1);
        sb_check();

        // Step press lands on the same edge as the 4th tick: old dir used.
        wait_cyc(1);
        btn_n = 2'b10;
        wait_cyc(7);
        ec = exp_up(ec);
        sb_push("dir_toggle_on_tick", ec, 2'd1, 1'b0, 1'b1);
        sb_check();
        wait_cyc(1);
        btn_n = 2'b11;
        wait_cyc(7);
        for (int k = 0; k < 20; k++) begin
            prev = ec;
            ec   = exp_dn(ec);
            sb_push($sformatf("down_tick_%0d", k), ec, 2'd1, 1'b0, 1'b1);
            sb_check();
            if (prev == 4'd0) break;
            wait_cyc(8);
        end

        // Into HOLD one cycle before the next tick would fire.
        btn_n = 2'b01;
        sb_push("to_hold", ec, 2'd2, 1'b0, 1'b0);
        wait_cyc(7);
        sb_check();
        wait_cyc(1);
        btn_n = 2'b11;
        sb_push("hold_no_ticks", ec, 2'd2, 1'b0, 1'b0);
        wait_cyc(16);
        sb_check();
        apply_vec('{mask: 2'b01, low: 8, idle: 10, cnt: 4'd0, mode: 2'd2, dir: 1'b0}, "hold_clear");
        apply_vec('{mask: 2'b10, low: 8, idle: 10, cnt: 4'd0, mode: 2'd0, dir: 1'b0}, "to_manual");

        // Reset mid-AUTO with step held.
        btn_n = 2'b01;
        sb_push("auto_again", 4'd0, 2'd1, 1'b0, 1'b0);
        wait_cyc(7);
        sb_check();
        wait_cyc(1);
        btn_n = 2'b11;
        wait_cyc(1);
        btn_n = 2'b10;
        wait_cyc(3);
        rst = 1'b1;
        sb_push("mid_reset", 4'd0, 2'd0, 1'b1, 1'b0);
        wait_cyc(1);
        sb_check();
        wait_cyc(1);
        rst = 1'b0;
        sb_push("held_before", 4'd0, 2'd0, 1'b1, 1'b0);
        wait_cyc(6);
        sb_check();
        sb_push("held_press", 4'd1, 2'd0, 1'b1, 1'b0);
        wait_cyc(1);
        sb_check();
        sb_push("held_once", 4'd1, 2'd0, 1'b1, 1'b0);
        wait_cyc(19);
        sb_check();
        btn_n = 2'b11;
        sb_push("held_release", 4'd1, 2'd0, 1'b1, 1'b0);
        wait_cyc(12);
        sb_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
